// File: rtl/echo_mux_fifo.sv
// echo_mux_fifo: multi-channel echo responder.
// Each channel owns a circular FIFO. Words are returned on the echo
// interface in per-channel arrival order, and the channels are served
// round-robin at one word per cycle.

// One channel's circular FIFO. A word written this cycle is visible at
// the head only from the next cycle, so an empty channel never bypasses.
module echo_chan_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNTW-1:0]  count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));
endmodule

module echo_mux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int NCHAN = 4,
  parameter int CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  parameter int PW    = $clog2(NCHAN * DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             say__ENA,
  input  logic [WIDTH-1:0] say_v,
  input  logic [CW-1:0]    say_ch,
  output logic             say__RDY,
  input  logic             echo__RDY,
  output logic             echo__ENA,
  output logic [WIDTH-1:0] echo_v,
  output logic [CW-1:0]    echo_ch,
  output logic [PW-1:0]    pending
);
  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] v;
  } echo_rsp_t;

  logic [NCHAN-1:0][WIDTH-1:0] head;
  logic [NCHAN-1:0]            empty, full, sel, wr_en, rd_en, elig;
  logic [CW-1:0]               rr_ptr, grant, scan_idx;
  logic                        found, enq;
  echo_rsp_t                   rsp;

  // Per-channel FIFOs, one instance per channel.
  genvar c;
  generate
    for (c = 0; c < NCHAN; c++) begin : g_chan
      // sel is all-zero for an out-of-range channel id, so such requests
      // see say__RDY=0 and never write anywhere.
      assign sel[c]   = (say_ch == CW'(c));
      assign wr_en[c] = say__ENA & sel[c] & ~full[c];
      assign rd_en[c] = echo__ENA & (grant == CW'(c));
      assign elig[c]  = ~empty[c];

      echo_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .wr_en   (wr_en[c]),
        .wr_data (say_v),
        .rd_en   (rd_en[c]),
        .head    (head[c]),
        .empty   (empty[c]),
        .full    (full[c])
      );
    end
  endgenerate

  assign say__RDY = |(sel & ~full);
  assign enq      = say__ENA & say__RDY;

  // Round-robin search: first eligible channel at or above rr_ptr, wrapping.
  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int i = 0; i < NCHAN; i++) begin
      scan_idx = CW'((int'(rr_ptr) + i) % NCHAN);
      if (!found && elig[scan_idx]) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  // Head word and channel are shown whenever something is eligible,
  // independent of echo__RDY; zero otherwise.
  always_comb begin
    rsp = '0;
    if (found) begin
      rsp.ch = grant;
      rsp.v  = head[grant];
    end
  end

  assign echo__ENA = echo__RDY & found;
  assign echo_v    = rsp.v;
  assign echo_ch   = rsp.ch;

  // rr_ptr moves past the channel just served; it holds while stalled.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (echo__ENA) begin
      rr_ptr <= (grant == CW'(NCHAN - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Running total of stored words: at most one in and one out per cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pending <= '0;
    end else begin
      pending <= pending + PW'(enq) - PW'(echo__ENA);
    end
  end
endmodule

// File: tb/tb_echo_mux_fifo.sv
// Bench for echo_mux_fifo: hand-computed vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_echo_mux_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int NCHAN = 4;
  localparam int CW    = 2;
  localparam int PW    = $clog2(NCHAN * DEPTH + 1);

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             say__ENA = 1'b0;
  logic [WIDTH-1:0] say_v = '0;
  logic [CW-1:0]    say_ch = '0;
  logic             say__RDY;
  logic             echo__RDY = 1'b0;
  logic             echo__ENA;
  logic [WIDTH-1:0] echo_v;
  logic [CW-1:0]    echo_ch;
  logic [PW-1:0]    pending;

  echo_mux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NCHAN(NCHAN)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .say__ENA  (say__ENA),
    .say_v     (say_v),
    .say_ch    (say_ch),
    .say__RDY  (say__RDY),
    .echo__RDY (echo__RDY),
    .echo__ENA (echo__ENA),
    .echo_v    (echo_v),
    .echo_ch   (echo_ch),
    .pending   (pending)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue per channel plus the round-robin start.
  logic [WIDTH-1:0] mq [NCHAN][$];
  int  rr_m = 0;
  bit  model_ok = 1'b0;

  // Values observed / predicted during the most recent drive() call.
  logic             o_srdy, o_ena;
  logic [WIDTH-1:0] o_v;
  logic [CW-1:0]    o_ch;
  int               o_pend;
  bit               m_srdy, m_ena;
  logic [WIDTH-1:0] m_v;
  int               m_ch, m_pend;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs with the model before the
  // edge, then advance the model by the transaction that edge performs.
  task automatic drive(input bit rst, input bit ena, input logic [CW-1:0] ch,
                       input logic [WIDTH-1:0] v, input bit rdy);
    int g;
    nRST = !rst; say__ENA = ena; say_ch = ch; say_v = v; echo__RDY = rdy;
    #1;
    g = -1;
    for (int i = 0; i < NCHAN; i++)
      if (g < 0 && mq[(rr_m + i) % NCHAN].size() != 0) g = (rr_m + i) % NCHAN;
    m_srdy = (int'(ch) < NCHAN) && (mq[ch].size() != DEPTH);
    m_ena  = rdy && (g >= 0);
    m_v    = (g >= 0) ? mq[g][0] : '0;
    m_ch   = (g >= 0) ? g : 0;
    m_pend = 0;
    for (int i = 0; i < NCHAN; i++) m_pend += mq[i].size();
    o_srdy = say__RDY; o_ena = echo__ENA; o_v = echo_v; o_ch = echo_ch; o_pend = int'(pending);
    if (model_ok) begin
      chk("model.say_rdy", {31'd0, o_srdy}, {31'd0, m_srdy});
      chk("model.echo_ena", {31'd0, o_ena}, {31'd0, m_ena});
      chk("model.echo_v", o_v, m_v);
      chk("model.echo_ch", {30'd0, o_ch}, m_ch);
      chk("model.pending", o_pend, m_pend);
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int i = 0; i < NCHAN; i++) mq[i].delete();
      rr_m = 0;
      model_ok = 1'b1;
    end else begin
      if (m_ena) begin
        void'(mq[g].pop_front());
        rr_m = (g + 1) % NCHAN;
      end
      if (ena && m_srdy) mq[ch].push_back(v);
    end
  endtask

  typedef struct {
    bit               rst, ena;
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] v;
    bit               rdy, cmp;
    bit               e_srdy, e_ena;
    logic [WIDTH-1:0] e_v;
    logic [CW-1:0]    e_ch;
    int               e_pend;
  } vec_t;
  vec_t tv[$];

  task automatic addv(input bit rst, input bit ena, input logic [CW-1:0] ch, input logic [WIDTH-1:0] v,
                      input bit rdy, input bit cmp, input bit e_srdy, input bit e_ena,
                      input logic [WIDTH-1:0] e_v, input logic [CW-1:0] e_ch, input int e_pend);
    vec_t r;
    r.rst = rst; r.ena = ena; r.ch = ch; r.v = v; r.rdy = rdy; r.cmp = cmp;
    r.e_srdy = e_srdy; r.e_ena = e_ena; r.e_v = e_v; r.e_ch = e_ch; r.e_pend = e_pend;
    tv.push_back(r);
  endtask

  initial begin
    bit saw_dead;
    // ---------------- vector table ----------------
    //   rst ena ch  v            rdy cmp srdy ena  echo_v       ch pend
    // reset, single echo
    addv(1, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0);
    addv(0, 0, 0, 0,            1, 1, 1, 0, 0,            0, 0);
    addv(0, 1, 0, 32'hA5A5A5A5, 1, 1, 1, 0, 0,            0, 0);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 32'hA5A5A5A5, 0, 1);
    addv(0, 0, 0, 0,            1, 1, 1, 0, 0,            0, 0);
    // fill ch2 while stalled, fifth write rejected, then drain
    addv(0, 1, 2, 1,            0, 1, 1, 0, 0,            0, 0);
    addv(0, 1, 2, 2,            0, 1, 1, 0, 1,            2, 1);
    addv(0, 1, 2, 3,            0, 1, 1, 0, 1,            2, 2);
    addv(0, 1, 2, 4,            0, 1, 1, 0, 1,            2, 3);
    addv(0, 1, 2, 5,            0, 1, 0, 0, 1,            2, 4);
    addv(0, 0, 1, 0,            0, 1, 1, 0, 1,            2, 4);
    addv(0, 0, 1, 0,            1, 1, 1, 1, 1,            2, 4);
    addv(0, 0, 1, 0,            1, 1, 1, 1, 2,            2, 3);
    addv(0, 0, 1, 0,            1, 1, 1, 1, 3,            2, 2);
    addv(0, 0, 1, 0,            1, 1, 1, 1, 4,            2, 1);
    addv(0, 0, 1, 0,            1, 1, 1, 0, 0,            0, 0);
    // round robin from a fresh reset
    addv(1, 0, 0, 0,            0, 0, 0, 0, 0,            0, 0);
    addv(0, 1, 0, 10,           0, 1, 1, 0, 0,            0, 0);
    addv(0, 1, 0, 11,           0, 1, 1, 0, 10,           0, 1);
    addv(0, 1, 1, 20,           0, 1, 1, 0, 10,           0, 2);
    addv(0, 1, 3, 30,           0, 1, 1, 0, 10,           0, 3);
    addv(0, 1, 3, 31,           0, 1, 1, 0, 10,           0, 4);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 10,           0, 5);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 20,           1, 4);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 30,           3, 3);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 11,           0, 2);
    addv(0, 0, 0, 0,            1, 1, 1, 1, 31,           3, 1);
    addv(0, 0, 0, 0,            1, 1, 1, 0, 0,            0, 0);

    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].ena, tv[k].ch, tv[k].v, tv[k].rdy);
      if (tv[k].cmp) begin
        chk($sformatf("vec%0d.say_rdy", k), {31'd0, o_srdy}, {31'd0, tv[k].e_srdy});
        chk($sformatf("vec%0d.echo_ena", k), {31'd0, o_ena}, {31'd0, tv[k].e_ena});
        chk($sformatf("vec%0d.echo_v", k), o_v, tv[k].e_v);
        chk($sformatf("vec%0d.echo_ch", k), {30'd0, o_ch}, {30'd0, tv[k].e_ch});
        chk($sformatf("vec%0d.pending", k), o_pend, tv[k].e_pend);
      end
    end

    // ---------------- wrap with concurrent enqueue/dequeue on ch1 ----------------
    for (int i = 0; i <= 10; i++) begin
      drive(0, i < 10, 1, 32'd100 + i, 1);
      if (i > 0) begin
        chk("wrap.ena", {31'd0, o_ena}, 32'd1);
        chk("wrap.v", o_v, 32'd100 + i - 1);
        chk("wrap.ch", {30'd0, o_ch}, 32'd1);
      end
      chk("wrap.pend_le1", {31'd0, o_pend <= 1}, 32'd1);
    end
    drive(0, 0, 1, 0, 1);
    chk("wrap.drained", {31'd0, o_ena}, 32'd0);

    // ---------------- full channel with simultaneous dequeue ----------------
    for (int i = 0; i < DEPTH; i++) drive(0, 1, 0, 32'd200 + i, 0);
    drive(0, 1, 0, 32'hDEAD, 1);
    chk("full.say_rdy", {31'd0, o_srdy}, 32'd0);
    chk("full.ena", {31'd0, o_ena}, 32'd1);
    chk("full.head", o_v, 32'd200);
    drive(0, 0, 0, 0, 1);
    chk("full.pend3", o_pend, 32'd3);
    saw_dead = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(0, 0, 0, 0, 1);
      if (o_ena && o_v == 32'hDEAD) saw_dead = 1'b1;
    end
    chk("full.no_drop_value", {31'd0, saw_dead}, 32'd0);

    // ---------------- reset mid-operation ----------------
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 0, 2, 0);
    drive(0, 1, 1, 3, 0);
    drive(0, 1, 2, 4, 0);
    drive(0, 1, 3, 5, 0);
    drive(0, 0, 0, 0, 0);
    chk("midrst.pend5", o_pend, 32'd5);
    drive(1, 1, 2, 9, 1);
    drive(0, 1, 3, 7, 1);
    chk("midrst.pend0", o_pend, 32'd0);
    chk("midrst.ena0", {31'd0, o_ena}, 32'd0);
    drive(0, 0, 0, 0, 1);
    chk("midrst.echo_ena", {31'd0, o_ena}, 32'd1);
    chk("midrst.echo_v", o_v, 32'd7);
    chk("midrst.echo_ch", {30'd0, o_ch}, 32'd3);
    chk("midrst.pend1", o_pend, 32'd1);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
            CW'($urandom_range(0, NCHAN - 1)), $urandom,
            $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/echo_mux_fifo.md
# echo_mux_fifo

Multi-channel echo responder: accepts `say` requests tagged with a channel number, buffers each channel in its own circular FIFO, and returns every word on the `echo` indication interface in per-channel arrival order. Channels are served round-robin, one word per cycle. It sits between the host request path and the indication path and replaces the single-channel, depth-1 echo with a parametrised block that can hold many requests.

## Interface

- `WIDTH`, 32: payload width in bits.
- `DEPTH`, 4: entries per channel FIFO. Must be a power of two, ≥2.
- `NCHAN`, 4: number of channels. Must be ≥1.
- `CW`, $clog2(NCHAN) (min 1): channel-id width.
- `CLK` input 1: clock. All state updates on the rising edge.
- `nRST` input 1: reset, synchronous, active-low.
- `say__ENA` input 1: request strobe. Legal only while `say__RDY`=1.
- `say_v` input WIDTH: request payload.
- `say_ch` input CW: request channel.
- `say__RDY` output 1: requested channel can accept a word.
- `echo__RDY` input 1: downstream can take an indication this cycle.
- `echo__ENA` output 1: indication issued this cycle.
- `echo_v` output WIDTH: indication payload.
- `echo_ch` output CW: channel the payload came from.
- `pending` output $clog2(NCHAN*DEPTH+1): total words held across all channels.

## Operation

- Per-channel state:
  - read pointer and write pointer, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, 0..DEPTH;
  - DEPTH×WIDTH storage.
- Enqueue when `say__ENA`=1:
  - `say_v` is written at the write pointer of channel `say_ch`;
  - that write pointer increments and that count increments.
- `say__RDY` = (count[`say_ch`] != DEPTH). It is combinational on `say_ch`.
- `say_ch` ≥ NCHAN: `say__RDY`=0 and the request is ignored.
- Grant selection:
  - Eligible = channels with count != 0.
  - Search starts at rr_ptr and moves upward, modulo NCHAN. The first eligible channel is granted.
- `echo__ENA` = `echo__RDY` & (any eligible).
- `echo_v` and `echo_ch` show the granted head word and its channel whenever any channel is eligible, regardless of `echo__RDY`. When no channel is eligible they are 0.
- On `echo__ENA`:
  - the granted channel's read pointer increments and its count decrements;
  - rr_ptr becomes (granted+1) mod NCHAN.
- rr_ptr holds when no word is issued.
- Same channel enqueued and dequeued in one cycle: count is unchanged and both pointers advance.
- Full channel: no enqueue, even if it is dequeued in the same cycle. `say__RDY` reflects the pre-edge count.
- Empty channel enqueued in cycle t: it is not eligible in cycle t (no bypass) and becomes eligible in t+1.
- `pending` = sum of all counts, registered. It is updated by +1, −1 or 0 each cycle.
- Storage contents are not reset. Pointers, counts, rr_ptr and `pending` are reset.

## Timing

- Reset: nRST=0 at a rising edge clears all counts, pointers, rr_ptr and `pending` to 0. This holds regardless of `say__ENA`/`echo__RDY` in that cycle, and any words in flight are discarded.
- Outputs after reset:
  - `say__RDY`=1 for any valid `say_ch`;
  - `echo__ENA`=0, `echo_v`=0, `echo_ch`=0, `pending`=0.
- Latency from `say__ENA` to the earliest `echo__ENA` of that word is 1 cycle, when the channel was empty, the word wins arbitration and `echo__RDY`=1.
- Throughput is one enqueue and one dequeue per cycle, on any channels.
- Each channel is strictly FIFO. There is no ordering guarantee across channels.
- Fairness: a channel that stays non-empty is granted within NCHAN consecutive `echo__ENA` cycles.
- `echo__RDY`=0 stalls all output. The FIFO state is frozen except for enqueues.
- Pointer wrap: after DEPTH enqueues a pointer returns to 0, and data order is preserved across the wrap.

## Test plan

- Reset and single echo:
  - Reset, then say(ch0, 0xA5A5A5A5) with `echo__RDY`=1.
  - Required: the next cycle shows `echo__ENA`=1, `echo_v`=0xA5A5A5A5, `echo_ch`=0; `pending` goes 0→1→0.
- Fill and overflow:
  - With `echo__RDY`=0, enqueue 1,2,3,4 to ch2 (DEPTH=4).
  - Required: `say__RDY`=0 for ch2 and 1 for ch1. A fifth enqueue attempt to ch2 is rejected. Raising `echo__RDY` yields 1,2,3,4 in order, then `echo__ENA`=0.
- Round-robin:
  - With `echo__RDY`=0, load ch0={10,11}, ch1={20}, ch3={30,31}, then hold `echo__RDY`=1.
  - Required sequence: (0,10),(1,20),(3,30),(0,11),(3,31).
- Wrap-around with concurrent enqueue and dequeue:
  - Stream 10 words to ch1 with `echo__RDY`=1 throughout.
  - Required: all 10 come out in order, one cycle later each, count never exceeds 1, and the pointers wrap twice.
- Full channel with simultaneous dequeue:
  - ch0 full; assert say(ch0) and `echo__RDY` in the same cycle.
  - Required: `say__RDY`=0, so no write occurs; count becomes 3 and the dropped value never appears.
- Reset mid-operation:
  - With 5 words pending across channels, pulse nRST=0 for one cycle.
  - Required: the next cycle shows `pending`=0 and `echo__ENA`=0. A new say(ch3, 7) is echoed as (3,7) with rr starting from ch0.
